// File: rtl/div_sub_pkg.sv
// div_sub_pkg: shared FSM encoding and width helpers for the multiply-add inverse divider
package div_sub_pkg;
    typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIX, DONE} state_t;
    // d = p - c needs one bit beyond the wider operand so it can never overflow
    function automatic int d_width(int p_w, int c_w);
        return (p_w > c_w ? p_w : c_w) + 1;
    endfunction
    function automatic int cnt_width(int d_w);
        return $clog2(d_w + 1);
    endfunction
endpackage

// File: rtl/udiv_core.sv
// udiv_core: unsigned restoring divider, one quotient bit per step
// clk/rst_n: clock, sync active-low reset; start: load n and dv; step: perform one iteration
// last: current step is the final one; quo/rem: unsigned quotient and remainder
module udiv_core
    import div_sub_pkg::*;
#(
    parameter int N_WIDTH = 49,
    parameter int V_WIDTH = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic [N_WIDTH-1:0] n,
    input  logic [V_WIDTH-1:0] dv,
    output logic               last,
    output logic [N_WIDTH-1:0] quo,
    output logic [V_WIDTH-1:0] rem
);
    localparam int CW = cnt_width(N_WIDTH);
    logic [V_WIDTH-1:0] dv_r;
    logic [CW-1:0]      cnt;
    logic [V_WIDTH:0]   sh;
    logic               keep;
    // quo starts as the dividend; its top bit feeds the partial remainder while quotient bits enter at the bottom
    assign sh   = {rem, quo[N_WIDTH-1]};
    assign keep = sh >= {1'b0, dv_r};
    assign last = cnt == CW'(N_WIDTH - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem  <= '0;
            quo  <= '0;
            dv_r <= '0;
            cnt  <= '0;
        end else if (start) begin
            rem  <= '0;
            quo  <= n;
            dv_r <= dv;
            cnt  <= '0;
        end else if (step) begin
            rem <= V_WIDTH'(keep ? sh - {1'b0, dv_r} : sh);
            quo <= {quo[N_WIDTH-2:0], keep};
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/div_sub.sv
// div_sub: recovers a = (p - c) / b with remainder, fixed-latency sequential divider
// in_valid/in_ready accept p, b, c; out_valid/out_ready present q, r, div_by_zero, overflow
module div_sub
    import div_sub_pkg::*;
#(
    parameter int A_DATA_WIDTH = 25,
    parameter int B_DATA_WIDTH = 18,
    parameter int C_DATA_WIDTH = 48,
    parameter int P_DATA_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [P_DATA_WIDTH-1:0] p,
    input  logic [B_DATA_WIDTH-1:0] b,
    input  logic [C_DATA_WIDTH-1:0] c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [A_DATA_WIDTH-1:0] q,
    output logic [B_DATA_WIDTH-1:0] r,
    output logic                    div_by_zero,
    output logic                    overflow
);
    localparam int DW = d_width(P_DATA_WIDTH, C_DATA_WIDTH);
    localparam logic [DW-1:0] Q_LIM = DW'(1) << (A_DATA_WIDTH - 1);
    state_t                  state, state_nx;
    logic [P_DATA_WIDTH-1:0] p_r;
    logic [B_DATA_WIDTH-1:0] b_r, b_mag, ur, r_fix;
    logic [C_DATA_WIDTH-1:0] c_r;
    logic [DW-1:0]           d, d_mag, uq;
    logic [A_DATA_WIDTH-1:0] q_fix;
    logic                    q_neg, r_neg, dz, last, ovf;
    assign d         = {{(DW-P_DATA_WIDTH){p_r[P_DATA_WIDTH-1]}}, p_r} - {{(DW-C_DATA_WIDTH){c_r[C_DATA_WIDTH-1]}}, c_r};
    assign d_mag     = d[DW-1] ? -d : d;
    assign b_mag     = b_r[B_DATA_WIDTH-1] ? -b_r : b_r;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    // a negative quotient may reach magnitude 2^(A-1), a positive one only 2^(A-1)-1
    assign ovf   = q_neg ? uq > Q_LIM : uq >= Q_LIM;
    assign q_fix = ovf ? {q_neg, {(A_DATA_WIDTH-1){!q_neg}}} : (q_neg ? -uq[A_DATA_WIDTH-1:0] : uq[A_DATA_WIDTH-1:0]);
    assign r_fix = r_neg ? -ur : ur;
    udiv_core #(.N_WIDTH(DW), .V_WIDTH(B_DATA_WIDTH)) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .start(state == PREP),
        .step (state == DIVIDE),
        .n    (d_mag),
        .dv   (b_mag),
        .last (last),
        .quo  (uq),
        .rem  (ur)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? PREP : IDLE;
            PREP:    state_nx = DIVIDE;
            DIVIDE:  state_nx = last ? FIX : DIVIDE;
            FIX:     state_nx = DONE;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            p_r         <= '0;
            b_r         <= '0;
            c_r         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                p_r         <= p;
                b_r         <= b;
                c_r         <= c;
                q           <= '0;
                r           <= '0;
                div_by_zero <= 1'b0;
                overflow    <= 1'b0;
            end
            if (state == PREP) begin
                q_neg <= d[DW-1] ^ b_r[B_DATA_WIDTH-1];
                r_neg <= d[DW-1];
                dz    <= b_r == '0;
            end
            if (state == FIX) begin
                q           <= dz ? '0 : q_fix;
                r           <= dz ? '0 : r_fix;
                div_by_zero <= dz;
                overflow    <= !dz && ovf;
            end
        end
    end
endmodule
